// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings, responder FSM state codes and the byte-lane helper
// for the SRAM slave.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    // Little-endian lane enables; only called for legal (aligned) sizes.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-wide SRAM with per-byte write enables and asynchronous read of the
// addressed word. Contents are never reset.
module ahb_sram_mem #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: address decode, legality check, wait-state/error FSM
// and output muxing around an ahb_sram_mem word array.
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);
    import ahb_sram_slave_pkg::*;

    localparam logic [3:0] WS = WAIT_STATES[3:0];

    logic [2:0]        state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;

    logic [31:0] offset;
    logic        ready;
    logic        accept;
    logic        illegal;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        unused_ok;

    assign offset = HADDR - BASE_ADDR;
    assign ready  = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign accept = HSEL && HREADY && HTRANS[1] && ready;

    // Alignment is checked on HADDR directly; BASE_ADDR is window-aligned.
    always_comb begin
        illegal = 1'b0;
        if (offset[31:ADDR_W+2] != '0) illegal = 1'b1;
        if (HSIZE > HSIZE_WORD) illegal = 1'b1;
        if ((HSIZE == HSIZE_HALF) && HADDR[0]) illegal = 1'b1;
        if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) illegal = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) state_d = ST_DATA;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d   = offset[ADDR_W+1:2];
                    lane_d  = HADDR[1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WS != 4'd0) begin
                        state_d = ST_WAIT;
                        wait_d  = WS;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Commit happens at the closing edge of the write data phase.
    assign mem_we = (state_q == ST_DATA) && write_q && !HRESET;

    ahb_sram_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk_i  (HCLK),
        .we_i   (mem_we),
        .be_i   (byte_enables(size_q, lane_q)),
        .addr_i (idx_q),
        .wdata_i(HWDATA),
        .rdata_o(mem_rdata)
    );

    assign HREADYOUT = ready;
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_rdata : '0;

    assign unused_ok = ^{HBURST, HTRANS[0], offset[1:0]};

endmodule
